// File: rtl/atmega_eep_pkg.sv
// Shared opcodes, response codes and FSM state type for the EEPROM maintenance loader.
package atmega_eep_pkg;

   localparam logic [7:0] CMD_DUMP = 8'h52;
   localparam logic [7:0] CMD_LOAD = 8'h57;
   localparam logic [7:0] CMD_STAT = 8'h53;

   localparam logic [7:0] RSP_ACK = 8'h06;
   localparam logic [7:0] RSP_NAK = 8'h15;

   typedef enum logic [2:0] {
      StIdle,
      StDumpAddr,
      StDumpWait,
      StDumpSend,
      StLoadRx,
      StLoadWr,
      StSendResp
   } state_e;

endpackage

// File: rtl/atmega_eep_loader_timeout.sv
// Clearable idle counter; tc flags the last cycle before LIMIT idle cycles have elapsed.
module atmega_eep_loader_timeout #(
   parameter int unsigned LIMIT = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   localparam int unsigned W = $clog2(LIMIT + 1);

   logic [W-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt_q <= '0;
      end else if (inc && !tc) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // tc is seen in the cycle that would make the count reach LIMIT.
   assign tc = (cnt_q == W'(LIMIT - 1));

endmodule

// File: rtl/atmega_eep_loader.sv
// Host maintenance port: dumps, loads and reports modified status of the EEPROM over a
// valid/ready byte link, stalling the CPU while it owns the EEPROM external port.
module atmega_eep_loader
   import atmega_eep_pkg::*;
#(
   parameter int unsigned EEP_SIZE       = 512,
   parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   output logic        rx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic [16:0] eep_addr,
   output logic [7:0]  eep_wdata,
   output logic        eep_wr,
   input  logic [7:0]  eep_rdata,
   output logic        eep_rd,
   output logic        eep_en,
   input  logic        eep_modified,
   output logic        cpu_stall,
   output logic        busy
);

   localparam logic [16:0] LAST_ADDR = 17'(EEP_SIZE - 1);

   state_e      state_q, state_d;
   logic [16:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic [7:0]  tx_data_q, tx_data_d;
   logic        armed_q;
   logic        rx_fire, tx_fire, last_addr, to_tc;

   // armed_q holds rx_ready low for the first cycle out of reset.
   assign rx_ready  = ((state_q == StIdle) && armed_q) || (state_q == StLoadRx);
   assign tx_valid  = (state_q == StDumpSend) || (state_q == StSendResp);
   assign eep_rd    = (state_q == StDumpAddr) || (state_q == StDumpWait);
   assign eep_wr    = (state_q == StLoadWr);
   assign eep_en    = eep_rd || eep_wr;
   assign cpu_stall = eep_en;
   assign busy      = (state_q != StIdle);
   assign eep_addr  = addr_q;
   assign eep_wdata = wdata_q;
   assign tx_data   = tx_data_q;

   assign rx_fire   = rx_valid && rx_ready;
   assign tx_fire   = tx_valid && tx_ready;
   assign last_addr = (addr_q == LAST_ADDR);

   atmega_eep_loader_timeout #(
      .LIMIT (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk (clk),
      .rst (rst),
      .clr ((state_q != StLoadRx) || rx_fire),
      .inc (state_q == StLoadRx),
      .tc  (to_tc)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      tx_data_d = tx_data_q;
      unique case (state_q)
         StIdle: begin
            if (rx_fire) begin
               case (rx_data)
                  CMD_DUMP: begin
                     addr_d  = '0;
                     state_d = StDumpAddr;
                  end
                  CMD_LOAD: begin
                     addr_d  = '0;
                     state_d = StLoadRx;
                  end
                  CMD_STAT: begin
                     tx_data_d = {7'b0, eep_modified};
                     state_d   = StSendResp;
                  end
                  default: begin
                     tx_data_d = RSP_NAK;
                     state_d   = StSendResp;
                  end
               endcase
            end
         end
         StDumpAddr: state_d = StDumpWait;
         StDumpWait: begin
            tx_data_d = eep_rdata;
            state_d   = StDumpSend;
         end
         StDumpSend: begin
            if (tx_fire) begin
               if (last_addr) begin
                  state_d = StIdle;
               end else begin
                  addr_d  = addr_q + 17'd1;
                  state_d = StDumpAddr;
               end
            end
         end
         StLoadRx: begin
            if (rx_fire) begin
               wdata_d = rx_data;
               state_d = StLoadWr;
            end else if (to_tc) begin
               tx_data_d = RSP_NAK;
               state_d   = StSendResp;
            end
         end
         StLoadWr: begin
            if (last_addr) begin
               tx_data_d = RSP_ACK;
               state_d   = StSendResp;
            end else begin
               addr_d  = addr_q + 17'd1;
               state_d = StLoadRx;
            end
         end
         StSendResp: begin
            if (tx_fire) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= StIdle;
         addr_q    <= '0;
         wdata_q   <= '0;
         tx_data_q <= '0;
         armed_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         tx_data_q <= tx_data_d;
         armed_q   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_atmega_eep_loader.sv
// Bench for atmega_eep_loader: 8-byte EEPROM model, command-level reference model and checks.
module tb_atmega_eep_loader;

   localparam int unsigned N  = 8;
   localparam int unsigned TO = 50;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b1;
   logic [16:0] eep_addr;
   logic [7:0]  eep_wdata;
   logic        eep_wr;
   logic [7:0]  eep_rdata;
   logic        eep_rd;
   logic        eep_en;
   logic        eep_modified;
   logic        cpu_stall;
   logic        busy;

   always #5 clk = ~clk;

   atmega_eep_loader #(
      .EEP_SIZE       (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_ready     (rx_ready),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .eep_addr     (eep_addr),
      .eep_wdata    (eep_wdata),
      .eep_wr       (eep_wr),
      .eep_rdata    (eep_rdata),
      .eep_rd       (eep_rd),
      .eep_en       (eep_en),
      .eep_modified (eep_modified),
      .cpu_stall    (cpu_stall),
      .busy         (busy)
   );

   // EEPROM: registered read, write on en&wr, sticky modified flag.
   logic [7:0] mem [N];
   logic       eep_mod;
   logic       preload = 1'b1;

   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < N; i++) mem[i] <= 8'h10 + 8'(i);
         eep_mod <= 1'b0;
      end else if (eep_en && eep_wr) begin
         mem[eep_addr[2:0]] <= eep_wdata;
         eep_mod            <= 1'b1;
      end
      if (eep_en && eep_rd) eep_rdata <= mem[eep_addr[2:0]];
   end
   assign eep_modified = eep_mod;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Command-level reference model.
   logic [7:0]  model_mem [N];
   bit          model_mod;
   bit          loading;
   int          idx;
   logic [7:0]  exp_tx [$];
   logic [24:0] exp_wr [$];
   int          tx_stamp [$];
   logic [7:0]  last_tx = 8'h00;
   int          cyc = 0;
   int          abort_req = 0;
   int          abort_seen = 0;
   bit          prev_hold;
   logic [7:0]  prev_data;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic model_byte(input logic [7:0] b);
      if (loading) begin
         model_mem[idx] = b;
         model_mod      = 1'b1;
         exp_wr.push_back({17'(idx), b});
         idx++;
         if (idx == N) begin
            loading = 1'b0;
            exp_tx.push_back(8'h06);
         end
      end else begin
         case (b)
            8'h52:   for (int i = 0; i < N; i++) exp_tx.push_back(model_mem[i]);
            8'h57: begin
               loading = 1'b1;
               idx     = 0;
            end
            8'h53:   exp_tx.push_back({7'b0, model_mod});
            default: exp_tx.push_back(8'h15);
         endcase
      end
   endtask

   always @(negedge clk) begin
      logic [7:0]  et;
      logic [24:0] ew;
      if (preload) begin
         for (int i = 0; i < N; i++) model_mem[i] = 8'h10 + 8'(i);
         model_mod = 1'b0;
      end
      if (rst) begin
         loading   = 1'b0;
         prev_hold = 1'b0;
         exp_tx.delete();
         exp_wr.delete();
      end else begin
         if (abort_req != abort_seen) begin
            abort_seen = abort_req;
            loading    = 1'b0;
            exp_tx.push_back(8'h15);
         end
         chk("wr_rd_exclusive", 32'(eep_wr & eep_rd), 0);
         chk("stall_eq_en", 32'(cpu_stall), 32'(eep_en));
         if (eep_en) chk("addr_in_range", 32'(eep_addr < N), 1);
         if (prev_hold) begin
            chk("tx_hold_valid", 32'(tx_valid), 1);
            chk("tx_hold_data", 32'(tx_data), 32'(prev_data));
         end
         if (eep_wr) begin
            chk("eep_wr_expected", 32'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
               ew = exp_wr.pop_front();
               chk("eep_wr_addr", 32'(eep_addr), 32'(ew[24:8]));
               chk("eep_wr_data", 32'(eep_wdata), 32'(ew[7:0]));
            end
         end
         if (tx_valid && tx_ready) begin
            tx_stamp.push_back(cyc);
            last_tx = tx_data;
            chk("tx_expected", 32'(exp_tx.size() != 0), 1);
            if (exp_tx.size() != 0) begin
               et = exp_tx.pop_front();
               chk("tx_data", 32'(tx_data), 32'(et));
            end
         end
         prev_hold = tx_valid && !tx_ready;
         prev_data = tx_data;
         if (rx_valid && rx_ready) model_byte(rx_data);
      end
   end

   task automatic send_rx(input logic [7:0] b);
      int n = 0;
      @(posedge clk); #1;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rx_accept", 32'(rx_ready), 1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n = 0;
      while ((exp_tx.size() != 0 || busy || tx_valid) && n < 500) begin
         @(negedge clk); #1;
         n++;
      end
      chk("drain_in_time", 32'(n < 500), 1);
      chk("no_pending_wr", 32'(exp_wr.size()), 0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_rx_ready"}, 32'(rx_ready), 0);
      chk({tag, "_tx_valid"}, 32'(tx_valid), 0);
      chk({tag, "_tx_data"}, 32'(tx_data), 0);
      chk({tag, "_eep_addr"}, 32'(eep_addr), 0);
      chk({tag, "_eep_wdata"}, 32'(eep_wdata), 0);
      chk({tag, "_eep_wr"}, 32'(eep_wr), 0);
      chk({tag, "_eep_rd"}, 32'(eep_rd), 0);
      chk({tag, "_eep_en"}, 32'(eep_en), 0);
      chk({tag, "_cpu_stall"}, 32'(cpu_stall), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
   endtask

   task automatic chk_mem(input string tag, input logic [63:0] img);
      for (int i = 0; i < N; i++) chk(tag, 32'(mem[i]), 32'(img[8*(7-i) +: 8]));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int base;
      int n;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk); #1;
      rst     = 1'b0;
      preload = 1'b0;
      @(negedge clk);
      chk("rx_ready_first_cycle", 32'(rx_ready), 0);
      @(negedge clk);
      chk("rx_ready_second_cycle", 32'(rx_ready), 1);

      // Status before any write.
      send_rx(8'h53);
      wait_drain();
      chk("stat_clean", 32'(last_tx), 32'h00);

      // Full dump at full rate: 3 cycles per byte, busy low right after the last byte.
      base = tx_stamp.size();
      send_rx(8'h52);
      n = 0;
      while (tx_stamp.size() < base + 8 && n < 200) begin
         @(negedge clk); #1;
         n++;
      end
      chk("dump_count", 32'(tx_stamp.size() - base), 8);
      @(negedge clk);
      chk("dump_busy_done", 32'(busy), 0);
      for (int i = 1; i < 8; i++) chk("dump_gap", 32'(tx_stamp[base+i] - tx_stamp[base+i-1]), 3);
      chk("dump_last", 32'(last_tx), 32'h17);
      wait_drain();

      // Back-pressured dump with a stray opcode held on rx.
      @(posedge clk); #1;
      tx_ready = 1'b0;
      send_rx(8'h52);
      for (int k = 0; k < 8; k++) begin
         n = 0;
         while (!tx_valid && n < 50) begin
            @(negedge clk);
            n++;
         end
         chk("bp_valid_seen", 32'(tx_valid), 1);
         if (k == 3) begin
            @(posedge clk); #1;
            rx_data  = 8'h52;
            rx_valid = 1'b1;
            repeat (20) begin
               @(negedge clk);
               chk("bp_data", 32'(tx_data), 32'h13);
               chk("bp_valid", 32'(tx_valid), 1);
               chk("bp_en", 32'(eep_en), 0);
               chk("bp_rx_ready", 32'(rx_ready), 0);
            end
         end
         @(posedge clk); #1;
         tx_ready = 1'b1;
         @(posedge clk); #1;
         tx_ready = 1'b0;
      end
      n = 0;
      @(negedge clk);
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("stray_accepted", 32'(rx_ready), 1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      tx_ready = 1'b1;
      wait_drain();
      chk("stray_dump_last", 32'(last_tx), 32'h17);

      // Load A0..A7, then read back and query status.
      send_rx(8'h57);
      for (int i = 0; i < 8; i++) send_rx(8'hA0 + 8'(i));
      wait_drain();
      chk("load_ack", 32'(last_tx), 32'h06);
      chk_mem("mem_after_load", 64'hA0A1A2A3A4A5A6A7);
      send_rx(8'h52);
      wait_drain();
      chk("reload_dump_last", 32'(last_tx), 32'hA7);
      send_rx(8'h53);
      wait_drain();
      chk("stat_modified", 32'(last_tx), 32'h01);

      // Timeout: 3 bytes (one with a long but legal gap), then silence.
      send_rx(8'h57);
      send_rx(8'hB0);
      repeat (40) @(posedge clk);
      send_rx(8'hB1);
      send_rx(8'hB2);
      abort_req++;
      n = 0;
      while (!tx_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      // One write cycle plus 50 idle cycles, response visible on the next one.
      chk("timeout_latency", 32'(n), 52);
      chk("timeout_nak_data", 32'(tx_data), 32'h15);
      wait_drain();
      chk("timeout_nak", 32'(last_tx), 32'h15);
      chk("timeout_idle", 32'(busy), 0);
      chk_mem("mem_after_timeout", 64'hB0B1B2A3A4A5A6A7);

      // Unknown opcode.
      send_rx(8'h00);
      wait_drain();
      chk("unknown_nak", 32'(last_tx), 32'h15);

      // Reset in the middle of a load.
      send_rx(8'h57);
      for (int i = 0; i < 4; i++) send_rx(8'hC0 + 8'(i));
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk_zero("mid_reset");
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rx_ready_first", 32'(rx_ready), 0);
      @(negedge clk);
      chk("mid_rx_ready_second", 32'(rx_ready), 1);
      chk_mem("mem_after_reset", 64'hC0C1C2C3A4A5A6A7);
      send_rx(8'h53);
      wait_drain();
      chk("stat_after_reset", 32'(last_tx), 32'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
